reg_if_stage_skid: RTL



---
 rtl/reg_if_stage_skid_pkg.sv | 15 +
 rtl/if_stage_entry.sv | 67 ++++++
 rtl/reg_if_stage_skid.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/reg_if_stage_skid_pkg.sv
// Shared definitions for the IF1/IF2 skid-buffered pipeline register.
package reg_if_stage_skid_pkg;

  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned PAY_W_DEF    = 1;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam int unsigned BP_TAKEN     = 0;

  typedef enum logic [1:0] {
    ENT_HOLD  = 2'd0,
    ENT_LOAD  = 2'd1,
    ENT_CLEAR = 2'd2
  } ent_op_e;

endpackage

// File: rtl/if_stage_entry.sv
// One registered fetch-beat entry {valid, pc, payload, ftag} with load/clear/hold control.
module if_stage_entry
  import reg_if_stage_skid_pkg::*;
#(
  parameter int unsigned      PC_W     = PC_W_DEF,
  parameter int unsigned      PAY_W    = PAY_W_DEF,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  ent_op_e          op,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [PAY_W-1:0] payload_i,
  input  logic             ftag_i,
  output logic             valid_o,
  output logic [PC_W-1:0]  pc_o,
  output logic [PAY_W-1:0] payload_o,
  output logic             ftag_o
);

  logic             valid_d, valid_q;
  logic [PC_W-1:0]  pc_d, pc_q;
  logic [PAY_W-1:0] payload_d, payload_q;
  logic             ftag_d, ftag_q;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    payload_d = payload_q;
    ftag_d    = ftag_q;
    case (op)
      ENT_LOAD: begin
        valid_d   = 1'b1;
        pc_d      = pc_i;
        payload_d = payload_i;
        ftag_d    = ftag_i;
      end
      ENT_CLEAR: begin
        valid_d   = 1'b0;
        pc_d      = RESET_PC;
        payload_d = '0;
        ftag_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      payload_q <= '0;
      ftag_q    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      payload_q <= payload_d;
      ftag_q    <= ftag_d;
    end
  end

  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign payload_o = payload_q;
  assign ftag_o    = ftag_q;

endmodule

// File: rtl/reg_if_stage_skid.sv
// IF1->IF2 valid/ready pipeline register with a 2-entry skid buffer and flush tagging.
module reg_if_stage_skid
  import reg_if_stage_skid_pkg::*;
#(
  parameter int unsigned      PC_W     = PC_W_DEF,
  parameter int unsigned      PAY_W    = PAY_W_DEF,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PAY_W-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [PAY_W-1:0] out_payload,
  output logic             out_flushed,
  output logic [1:0]       occupancy
);

  logic             main_valid, skid_valid;
  logic [PC_W-1:0]  main_pc, skid_pc;
  logic [PAY_W-1:0] main_payload, skid_payload;
  logic             main_ftag, skid_ftag;

  ent_op_e          main_op, skid_op;
  logic             main_from_skid;
  logic [PC_W-1:0]  main_pc_in;
  logic [PAY_W-1:0] main_payload_in;
  logic             main_ftag_in;

  logic             in_ready_d, in_ready_q;
  logic             flush_pend_d, flush_pend_q;
  logic [1:0]       occupancy_d, occupancy_q;
  logic             main_valid_nx, skid_valid_nx;
  logic             accept, pop;

  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = main_valid & out_ready;

  // Entry sequencing; next valids are tracked here so in_ready/occupancy can be registered.
  always_comb begin
    main_op        = ENT_HOLD;
    skid_op        = ENT_HOLD;
    main_from_skid = 1'b0;
    main_valid_nx  = main_valid;
    skid_valid_nx  = skid_valid;
    flush_pend_d   = flush_pend_q;
    if (flush) begin
      main_op       = ENT_CLEAR;
      skid_op       = ENT_CLEAR;
      main_valid_nx = 1'b0;
      skid_valid_nx = 1'b0;
      flush_pend_d  = 1'b1;
    end else begin
      if (accept) flush_pend_d = 1'b0;
      if (!main_valid) begin
        if (accept) begin
          main_op       = ENT_LOAD;
          main_valid_nx = 1'b1;
        end
      end else if (!pop) begin
        if (accept) begin
          skid_op       = ENT_LOAD;
          skid_valid_nx = 1'b1;
        end
      end else if (skid_valid) begin
        main_op        = ENT_LOAD;
        main_from_skid = 1'b1;
        skid_op        = ENT_CLEAR;
        skid_valid_nx  = 1'b0;
      end else if (accept) begin
        main_op = ENT_LOAD;
      end else begin
        main_op       = ENT_CLEAR;
        main_valid_nx = 1'b0;
      end
    end
    in_ready_d  = ~skid_valid_nx;
    occupancy_d = {1'b0, main_valid_nx} + {1'b0, skid_valid_nx};
  end

  always_comb begin
    main_pc_in      = in_pc;
    main_payload_in = in_payload;
    main_ftag_in    = flush_pend_q;
    if (main_from_skid) begin
      main_pc_in      = skid_pc;
      main_payload_in = skid_payload;
      main_ftag_in    = skid_ftag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b1;
      flush_pend_q <= 1'b0;
      occupancy_q  <= 2'd0;
    end else begin
      in_ready_q   <= in_ready_d;
      flush_pend_q <= flush_pend_d;
      occupancy_q  <= occupancy_d;
    end
  end

  if_stage_entry #(.PC_W(PC_W), .PAY_W(PAY_W), .RESET_PC(RESET_PC)) u_main (
    .clk       (clk),
    .rst       (rst),
    .op        (main_op),
    .pc_i      (main_pc_in),
    .payload_i (main_payload_in),
    .ftag_i    (main_ftag_in),
    .valid_o   (main_valid),
    .pc_o      (main_pc),
    .payload_o (main_payload),
    .ftag_o    (main_ftag)
  );

  if_stage_entry #(.PC_W(PC_W), .PAY_W(PAY_W), .RESET_PC(RESET_PC)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .op        (skid_op),
    .pc_i      (in_pc),
    .payload_i (in_payload),
    .ftag_i    (flush_pend_q),
    .valid_o   (skid_valid),
    .pc_o      (skid_pc),
    .payload_o (skid_payload),
    .ftag_o    (skid_ftag)
  );

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid;
  assign out_pc      = main_pc;
  assign out_payload = main_payload;
  assign out_flushed = main_ftag;
  assign occupancy   = occupancy_q;

endmodule
